router_ctrl: RTL and testbench

Input-side packet controller for the 1x3 router. It frames incoming bytes into packets, captures the destination header, and drives `get_dest`, `dest_out` and `write_enb_reg` into the FIFO-select logic. It stages payload bytes through a one-entry output register and stalls the sender while the selected FIFO is full. It also checks a trailing parity byte and keeps packet and drop counters.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_out_stage.sv | 41 ++++
 rtl/router_ctrl.sv | 162 ++++++++++++++++
 tb/tb_router_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared FSM state encoding and destination decoding for the
// router input controller and the FIFO-select logic.
package router_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP    = 2'd2,
      ST_CHECK   = 2'd3
   } state_t;

   // Destinations that no FIFO decodes.
   localparam logic [7:0] DEST_BAD_0 = 8'd0;
   localparam logic [7:0] DEST_BAD_1 = 8'd128;
   localparam logic [7:0] DEST_BAD_2 = 8'd196;

   // Same ranges the FIFO-select logic decodes: 1-127, 129-195, 197-255.
   function automatic logic dest_valid(input logic [7:0] dest);
      return (dest != DEST_BAD_0) && (dest != DEST_BAD_1) && (dest != DEST_BAD_2);
   endfunction

endpackage

// File: rtl/router_out_stage.sv
// router_out_stage: one-entry output register between the sender and the
// selected FIFO. Drains whenever the FIFO is not full and may be reloaded in
// the same cycle, so a full-rate stream passes with no bubbles.
module router_out_stage
   import router_pkg::*;
(
   input  logic       clk1,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       fifo_full,
   output logic [7:0] data_out,
   output logic       out_vld,
   output logic       write_enb_reg,
   output logic       stall
);

   assign write_enb_reg = out_vld & ~fifo_full;
   assign stall         = out_vld & fifo_full;

   // Occupancy flag: a load wins over a drain in the same cycle.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         out_vld <= 1'b0;
      end else if (load) begin
         out_vld <= 1'b1;
      end else if (write_enb_reg) begin
         out_vld <= 1'b0;
      end
   end

   // Staged byte: only replaced on a load so it is held while the FIFO is full.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         data_out <= 8'd0;
      end else if (load) begin
         data_out <= load_data;
      end
   end

endmodule

// File: rtl/router_ctrl.sv
// router_ctrl: input-side packet controller of the 1x3 router. Frames bytes
// into packets, captures the destination header, stages payload/parity bytes
// through router_out_stage and keeps packet/drop counters.
// Build option: define ROUTER_CTRL_PARITY_CHECK_EN to build the XOR parity
// accumulator and comparator; otherwise err is tied low. The FSM sequence and
// timing are identical in both builds.
module router_ctrl
   import router_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk1,
   input  logic             reset,
   input  logic             pkt_valid,
   input  logic             pkt_last,
   input  logic [7:0]       data_in,
   input  logic             fifo_full,
   output logic             busy,
   output logic             get_dest,
   output logic [7:0]       dest_out,
   output logic             write_enb_reg,
   output logic [7:0]       data_out,
   output logic             err,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   state_t state, state_nxt;
   logic   accept;
   logic   stall;
   logic   out_vld;
   logic   load;
   logic   hdr_take;
   logic   dest_ok;
   logic   pkt_done;
   logic   drop_done;

   assign busy   = stall | (state == ST_CHECK);
   assign accept = pkt_valid & ~busy;

   router_out_stage u_out_stage (
      .clk1          (clk1),
      .reset         (reset),
      .load          (load),
      .load_data     (data_in),
      .fifo_full     (fifo_full),
      .data_out      (data_out),
      .out_vld       (out_vld),
      .write_enb_reg (write_enb_reg),
      .stall         (stall)
   );

   // State register.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-cycle control decisions.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      hdr_take  = 1'b0;
      dest_ok   = 1'b0;
      pkt_done  = 1'b0;
      drop_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               hdr_take = 1'b1;
               if (pkt_last) begin
                  // A header that is also the last byte is malformed.
                  drop_done = 1'b1;
               end else if (dest_valid(data_in)) begin
                  dest_ok   = 1'b1;
                  state_nxt = ST_PAYLOAD;
               end else begin
                  state_nxt = ST_DROP;
               end
            end
         end
         ST_PAYLOAD: begin
            if (accept) begin
               load = 1'b1;
               if (pkt_last) begin
                  pkt_done  = 1'b1;
                  state_nxt = ST_CHECK;
               end
            end
         end
         ST_DROP: begin
            if (accept && pkt_last) begin
               drop_done = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_CHECK: begin
            // Leave once the parity byte is written (or already gone), so
            // dest_out cannot change under a staged byte.
            if (!out_vld || write_enb_reg) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Destination register and the one-cycle get_dest pulse.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         dest_out <= 8'd0;
         get_dest <= 1'b0;
      end else begin
         get_dest <= dest_ok;
         if (hdr_take) begin
            dest_out <= data_in;
         end
      end
   end

   // Forwarded and dropped packet counters, wrapping.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (pkt_done) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1);
         end
         if (drop_done) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

`ifdef ROUTER_CTRL_PARITY_CHECK_EN
   logic [7:0] parity;

   // Running XOR over header and payload; compared against the parity byte.
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         parity <= 8'd0;
         err    <= 1'b0;
      end else begin
         err <= pkt_done & (data_in != parity);
         if (dest_ok) begin
            parity <= data_in;
         end else if (load && !pkt_last) begin
            parity <= parity ^ data_in;
         end
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed and randomized bench for router_ctrl with a
// packet-level reference model and a per-cycle output compare.
module tb_router_ctrl;

   localparam int CNT_W = 8;
`ifdef ROUTER_CTRL_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic             clk1      = 1'b0;
   logic             reset     = 1'b1;
   logic             pkt_valid = 1'b0;
   logic             pkt_last  = 1'b0;
   logic [7:0]       data_in   = 8'd0;
   logic             fifo_full = 1'b0;
   logic             busy;
   logic             get_dest;
   logic [7:0]       dest_out;
   logic             write_enb_reg;
   logic [7:0]       data_out;
   logic             err;
   logic [CNT_W-1:0] pkt_cnt;
   logic [CNT_W-1:0] drop_cnt;

   router_ctrl #(.CNT_W(CNT_W)) dut (
      .clk1          (clk1),
      .reset         (reset),
      .pkt_valid     (pkt_valid),
      .pkt_last      (pkt_last),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .busy          (busy),
      .get_dest      (get_dest),
      .dest_out      (dest_out),
      .write_enb_reg (write_enb_reg),
      .data_out      (data_out),
      .err           (err),
      .pkt_cnt       (pkt_cnt),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk1 = ~clk1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: packet phase 0=expect header, 1=payload, 2=dropping.
   int         m_phase;
   bit         m_check, m_staged, m_get_dest, m_err;
   logic [7:0] m_stage, m_dest, m_par;
   int         m_pkt, m_drop;

   // Observations of the DUT used by directed checks.
   logic [7:0] wr_log[$];
   int         gd_seen, err_seen;
   bit         rand_full = 1'b0;
   logic [7:0] bad_dest[3] = '{8'd0, 8'd128, 8'd196};

   function automatic bit dest_is_valid(input logic [7:0] d);
      return (d >= 8'd1 && d <= 8'd127) || (d >= 8'd129 && d <= 8'd195) || (d >= 8'd197);
   endfunction

   // Compare DUT against the model on the falling edge, then advance the model
   // by what the coming rising edge must do.
   always @(negedge clk1) begin
      bit exp_we;
      bit exp_busy;
      bit acc;
      if (reset) begin
         m_phase = 0; m_check = 0; m_staged = 0; m_get_dest = 0; m_err = 0;
         m_stage = 0; m_dest = 0; m_par = 0; m_pkt = 0; m_drop = 0;
         chk("rst_busy", busy, 0);
         chk("rst_we", write_enb_reg, 0);
         chk("rst_get_dest", get_dest, 0);
         chk("rst_dest_out", dest_out, 0);
         chk("rst_data_out", data_out, 0);
         chk("rst_err", err, 0);
         chk("rst_pkt_cnt", pkt_cnt, 0);
         chk("rst_drop_cnt", drop_cnt, 0);
      end else begin
         exp_we   = m_staged & ~fifo_full;
         exp_busy = (m_staged & fifo_full) | m_check;
         chk("busy", busy, exp_busy);
         chk("write_enb_reg", write_enb_reg, exp_we);
         chk("get_dest", get_dest, m_get_dest);
         chk("dest_out", dest_out, m_dest);
         chk("err", err, m_err);
         chk("pkt_cnt", pkt_cnt, m_pkt & 8'hFF);
         chk("drop_cnt", drop_cnt, m_drop & 8'hFF);
         if (m_staged) chk("data_out", data_out, m_stage);
         if (write_enb_reg) wr_log.push_back(data_out);
         if (get_dest) gd_seen++;
         if (err) err_seen++;

         m_get_dest = 0;
         m_err      = 0;
         if (m_check && (!m_staged || exp_we)) m_check = 0;
         if (exp_we) m_staged = 0;
         acc = pkt_valid && !exp_busy;
         if (acc) begin
            case (m_phase)
               0: begin
                  m_dest = data_in;
                  if (pkt_last) m_drop++;
                  else if (dest_is_valid(data_in)) begin
                     m_phase = 1; m_get_dest = 1; m_par = data_in;
                  end else m_phase = 2;
               end
               1: begin
                  m_staged = 1;
                  m_stage  = data_in;
                  if (pkt_last) begin
                     m_pkt++;
                     m_phase = 0;
                     m_check = 1;
                     m_err   = PAR_EN && (data_in != m_par);
                  end else m_par = m_par ^ data_in;
               end
               default: begin
                  if (pkt_last) begin
                     m_drop++;
                     m_phase = 0;
                  end
               end
            endcase
         end
      end
   end

   // Random back-pressure when enabled.
   initial begin
      forever begin
         @(posedge clk1);
         #1;
         if (rand_full) fifo_full = ($urandom_range(0, 9) < 3);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk1);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input bit last);
      bit acc;
      int n;
      n = 0;
      pkt_valid = 1'b1;
      data_in   = d;
      pkt_last  = last;
      forever begin
         @(negedge clk1);
         acc = !busy;
         @(posedge clk1);
         #1;
         if (acc) break;
         n++;
         if (n > 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=busy required=accept");
            break;
         end
      end
      pkt_valid = 1'b0;
      pkt_last  = 1'b0;
   endtask

   task automatic drain();
      pkt_valid = 1'b0;
      pkt_last  = 1'b0;
      repeat (4) cyc();
   endtask

   task automatic clear_obs();
      wr_log.delete();
      gd_seen  = 0;
      err_seen = 0;
   endtask

   task automatic check_log(input string nm, input int n, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [7:0] e2);
      logic [7:0] e[3];
      e[0] = e0; e[1] = e1; e[2] = e2;
      chk({nm, "_len"}, wr_log.size(), n);
      for (int i = 0; i < n && i < wr_log.size(); i++) chk({nm, "_byte"}, wr_log[i], e[i]);
   endtask

   initial begin
      logic [7:0] h, b, par;
      int         kind, len;

      clear_obs();
      repeat (3) cyc();
      chk("reset_busy_lit", busy, 0);
      chk("reset_pkt_cnt_lit", pkt_cnt, 0);
      reset = 1'b0;
      cyc();

      // Good packet 10 / 11 22 / parity 39.
      clear_obs();
      send(8'd10, 0); send(8'h11, 0); send(8'h22, 0); send(8'h39, 1);
      drain();
      check_log("t1_writes", 3, 8'h11, 8'h22, 8'h39);
      chk("t1_get_dest_pulses", gd_seen, 1);
      chk("t1_dest_out", dest_out, 8'd10);
      chk("t1_err_pulses", err_seen, 0);
      chk("t1_pkt_cnt", pkt_cnt, 1);

      // Same packet, wrong parity.
      clear_obs();
      send(8'd10, 0); send(8'h11, 0); send(8'h22, 0); send(8'h00, 1);
      drain();
      check_log("t2_writes", 3, 8'h11, 8'h22, 8'h00);
      chk("t2_err_pulses", err_seen, PAR_EN ? 1 : 0);
      chk("t2_pkt_cnt", pkt_cnt, 2);

      // FIFO full for two cycles while 22 is staged.
      clear_obs();
      send(8'd10, 0); send(8'h11, 0); send(8'h22, 0);
      fifo_full = 1'b1;
      pkt_valid = 1'b1; data_in = 8'h39; pkt_last = 1'b1;
      repeat (2) begin
         @(negedge clk1);
         chk("t3_busy_full", busy, 1);
         chk("t3_we_full", write_enb_reg, 0);
         chk("t3_data_held", data_out, 8'h22);
         cyc();
      end
      fifo_full = 1'b0;
      send(8'h39, 1);
      drain();
      check_log("t3_writes", 3, 8'h11, 8'h22, 8'h39);
      chk("t3_pkt_cnt", pkt_cnt, 3);

      // Invalid destination is dropped, next packet forwards.
      clear_obs();
      send(8'd128, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 1);
      drain();
      chk("t4_drop_cnt", drop_cnt, 1);
      chk("t4_get_dest_pulses", gd_seen, 0);
      chk("t4_writes_len", wr_log.size(), 0);
      chk("t4_dest_loaded", dest_out, 8'd128);
      clear_obs();
      send(8'd200, 0); send(8'h33, 0); send(8'hFB, 1);
      drain();
      check_log("t4b_writes", 2, 8'h33, 8'hFB, 8'h00);
      chk("t4b_get_dest_pulses", gd_seen, 1);
      chk("t4b_dest_out", dest_out, 8'd200);
      chk("t4b_pkt_cnt", pkt_cnt, 4);
      chk("t4b_err_pulses", err_seen, 0);

      // Reset in the middle of a packet.
      send(8'd77, 0); send(8'h01, 0); send(8'h02, 0);
      reset = 1'b1;
      cyc();
      chk("t5_rst_pkt_cnt", pkt_cnt, 0);
      chk("t5_rst_drop_cnt", drop_cnt, 0);
      chk("t5_rst_busy", busy, 0);
      cyc();
      reset = 1'b0;
      cyc();
      clear_obs();
      send(8'd5, 0); send(8'hA5, 0); send(8'hA0, 1);
      drain();
      check_log("t5_writes", 2, 8'hA5, 8'hA0, 8'h00);
      chk("t5_pkt_cnt", pkt_cnt, 1);
      chk("t5_drop_cnt", drop_cnt, 0);
      chk("t5_dest_out", dest_out, 8'd5);

      // Randomized traffic with gaps and back-pressure.
      rand_full = 1'b1;
      for (int p = 0; p < 150; p++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) h = bad_dest[$urandom_range(0, 2)];
         else h = 8'($urandom_range(1, 255));
         if (kind == 1) begin
            send(h, 1);
         end else begin
            send(h, 0);
            par = h;
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) begin
               b = 8'($urandom);
               repeat ($urandom_range(0, 2)) cyc();
               send(b, 0);
               par = par ^ b;
            end
            if ($urandom_range(0, 3) == 0) par = 8'($urandom);
            send(par, 1);
         end
         repeat ($urandom_range(0, 1)) cyc();
      end
      rand_full = 1'b0;
      cyc();
      fifo_full = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
